// File: rtl/instr_loader_pkg.sv
// instr_loader_pkg
//   Shared definitions for the instruction-memory boot loader: the loader
//   state encoding, default status bytes and counter widths.
package instr_loader_pkg;

    typedef enum logic [2:0] {
        ST_LEN  = 3'd0,
        ST_DATA = 3'd1,
        ST_ACK  = 3'd2,
        ST_RUN  = 3'd3,
        ST_ERR  = 3'd4
    } state_e;

    localparam logic [7:0] ACK_BYTE_DEF = 8'hAA;
    localparam logic [7:0] ERR_BYTE_DEF = 8'hEE;

    localparam int BCNT_W = 2;   // byte position inside a 32-bit word
    localparam int WIDX_W = 16;  // loaded-word index
    localparam int WORD_W = 32;

endpackage

// File: rtl/instr_loader_byte_assembler.sv
// byte_assembler
//   Packs a byte stream into little-endian 32-bit words (first byte -> [7:0]).
//   Ports:
//     clk, rst    clock, asynchronous active-high reset
//     clear       drop any partial word and restart at byte 0
//     byte_valid  byte_data is valid this cycle
//     byte_data   incoming byte
//     word_valid  1-cycle pulse, same cycle as the 4th byte of a word
//     word        assembled word, valid while word_valid is high
module byte_assembler
    import instr_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              word_valid,
    output logic [WORD_W-1:0] word
);

    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic [23:0]       shreg_q, shreg_d;

    // Only the first three bytes need storage; the fourth is used straight
    // from the input so the word is available in the cycle it completes.
    assign word       = {byte_data, shreg_q};
    assign word_valid = byte_valid && !clear && (bcnt_q == BCNT_W'(3));

    always_comb begin
        bcnt_d  = bcnt_q;
        shreg_d = shreg_q;
        if (clear) begin
            bcnt_d = '0;
        end else if (byte_valid) begin
            bcnt_d  = bcnt_q + BCNT_W'(1);  // wraps 3 -> 0 at word end
            shreg_d = {byte_data, shreg_q[23:8]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt_q  <= '0;
            shreg_q <= '0;
        end else begin
            bcnt_q  <= bcnt_d;
            shreg_q <= shreg_d;
        end
    end

endmodule

// File: rtl/instr_loader.sv
// instr_loader
//   Boot-time sequencer: receives a length-prefixed program image over the
//   UART byte stream, writes it into instruction memory through the I/O-side
//   port, returns a status byte and then releases the processor.
//   Ports:
//     clk, rst             clock, asynchronous active-high reset
//     rx_valid, rx_data    received byte stream (1-cycle pulse per byte)
//     tx_valid, tx_ready,
//     tx_data              status byte handshake towards the UART transmitter
//     reload               synchronous restart of the load from any state
//     mem_we, mem_io_sel,
//     mem_addr, mem_din    instruction memory I/O-side write port
//     cpu_run              1 releases the processor from hold
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 32768,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter logic [7:0]  ACK_BYTE    = ACK_BYTE_DEF,
    parameter logic [7:0]  ERR_BYTE    = ERR_BYTE_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    input  logic        reload,
    output logic        mem_we,
    output logic        mem_io_sel,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic        cpu_run
);

    state_e              state_q;
    logic [WORD_W-1:0]   len_q;
    logic [WIDX_W-1:0]   widx_q;
    logic [WIDX_W-1:0]   widx_d;
    logic                we_q, io_sel_q, run_q, txv_q;
    logic [31:0]         addr_q, din_q;
    logic [7:0]          txd_q;

    logic                asm_valid;
    logic                word_valid;
    logic [WORD_W-1:0]   word;

    // Bytes are only consumed while collecting length or data; a byte in the
    // same cycle as reload is dropped so it cannot start the new image.
    assign asm_valid = rx_valid && !reload && (state_q == ST_LEN || state_q == ST_DATA);
    assign widx_d    = widx_q + WIDX_W'(1);

    byte_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (reload),
        .byte_valid (asm_valid),
        .byte_data  (rx_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_LEN;
            len_q    <= '0;
            widx_q   <= '0;
            we_q     <= 1'b0;
            io_sel_q <= 1'b1;
            run_q    <= 1'b0;
            addr_q   <= BASE_ADDR;
            din_q    <= '0;
            txv_q    <= 1'b0;
            txd_q    <= '0;
        end else begin
            // Write strobe is a single-cycle pulse; an already registered
            // write still completes even if reload arrives during it.
            we_q <= 1'b0;
            if (reload) begin
                state_q  <= ST_LEN;
                widx_q   <= '0;
                run_q    <= 1'b0;
                io_sel_q <= 1'b1;
                txv_q    <= 1'b0;
            end else begin
                case (state_q)
                    ST_LEN: begin
                        if (word_valid) begin
                            len_q <= word;
                            if (word > DEPTH_WORDS) begin
                                state_q <= ST_ERR;
                                txv_q   <= 1'b1;
                                txd_q   <= ERR_BYTE;
                            end else if (word == '0) begin
                                state_q <= ST_ACK;
                                txv_q   <= 1'b1;
                                txd_q   <= ACK_BYTE;
                            end else begin
                                state_q <= ST_DATA;
                                widx_q  <= '0;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (word_valid) begin
                            we_q   <= 1'b1;
                            din_q  <= word;
                            addr_q <= BASE_ADDR + {{(32-WIDX_W-2){1'b0}}, widx_q, 2'b00};
                            widx_q <= widx_d;
                            // Last word: status goes out alongside its write.
                            if ({{(WORD_W-WIDX_W){1'b0}}, widx_d} == len_q) begin
                                state_q <= ST_ACK;
                                txv_q   <= 1'b1;
                                txd_q   <= ACK_BYTE;
                            end
                        end
                    end
                    ST_ACK: begin
                        if (tx_ready) begin
                            txv_q    <= 1'b0;
                            state_q  <= ST_RUN;
                            io_sel_q <= 1'b0;
                            run_q    <= 1'b1;
                        end
                    end
                    ST_ERR: begin
                        // Processor stays held; only reload or rst leaves here.
                        if (txv_q && tx_ready) begin
                            txv_q <= 1'b0;
                        end
                    end
                    default: ;  // ST_RUN: memory belongs to the processor
                endcase
            end
        end
    end

    assign mem_we     = we_q;
    assign mem_io_sel = io_sel_q;
    assign mem_addr   = addr_q;
    assign mem_din    = din_q;
    assign cpu_run    = run_q;
    assign tx_valid   = txv_q;
    assign tx_data    = txd_q;

endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic [7:0]  tx_data;
    logic        reload = 1'b0;
    logic        mem_we;
    logic        mem_io_sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic        cpu_run;

    instr_loader dut (
        .clk        (clk),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .reload     (reload),
        .mem_we     (mem_we),
        .mem_io_sel (mem_io_sel),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .cpu_run    (cpu_run)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phases of the boot protocol as seen from the outside.
    localparam int P_LEN = 0, P_DATA = 1, P_STATUS_OK = 2, P_RUNNING = 3, P_FAILED = 4;
    int          m_phase = P_LEN;
    logic [7:0]  m_bytes[$];
    logic [31:0] m_len = 0;
    int          m_k = 0;
    logic        e_we = 0, e_iosel = 1, e_run = 0, e_txv = 0;
    logic [31:0] e_addr = 0, e_din = 0;
    logic [7:0]  e_txd = 0;

    always @(posedge clk) begin
        logic [31:0] w;
        e_we = 1'b0;
        if (rst) begin
            m_phase = P_LEN; m_bytes.delete(); m_len = 0; m_k = 0;
            e_iosel = 1; e_run = 0; e_txv = 0; e_addr = 0; e_din = 0; e_txd = 0;
        end else if (reload) begin
            m_phase = P_LEN; m_bytes.delete(); m_k = 0;
            e_run = 0; e_iosel = 1; e_txv = 0;
        end else if (m_phase == P_LEN || m_phase == P_DATA) begin
            if (rx_valid) begin
                m_bytes.push_back(rx_data);
                if (m_bytes.size() == 4) begin
                    w = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
                    m_bytes.delete();
                    if (m_phase == P_LEN) begin
                        m_len = w;
                        if (w > 32768) begin
                            m_phase = P_FAILED; e_txv = 1; e_txd = 8'hEE;
                        end else if (w == 0) begin
                            m_phase = P_STATUS_OK; e_txv = 1; e_txd = 8'hAA;
                        end else begin
                            m_phase = P_DATA; m_k = 0;
                        end
                    end else begin
                        e_we = 1; e_addr = 32'(m_k * 4); e_din = w;
                        m_k++;
                        if (m_k == int'(m_len)) begin
                            m_phase = P_STATUS_OK; e_txv = 1; e_txd = 8'hAA;
                        end
                    end
                end
            end
        end else if (m_phase == P_STATUS_OK) begin
            if (e_txv && tx_ready) begin
                e_txv = 0; m_phase = P_RUNNING; e_run = 1; e_iosel = 0;
            end
        end else if (m_phase == P_FAILED) begin
            if (e_txv && tx_ready) e_txv = 0;
        end
    end

    // ---------------- per-cycle compare + logs ----------------
    logic [31:0] wlog_addr[$], wlog_din[$];
    int          wlog_cyc[$];
    logic [7:0]  txlog_data[$];
    int          txlog_cyc[$];
    int          run_rise_cyc = -1;
    logic        run_prev = 0;

    always @(negedge clk) begin
        check("mem_we",     {31'd0, mem_we},     {31'd0, e_we});
        check("mem_io_sel", {31'd0, mem_io_sel}, {31'd0, e_iosel});
        check("mem_addr",   mem_addr,            e_addr);
        check("mem_din",    mem_din,             e_din);
        check("cpu_run",    {31'd0, cpu_run},    {31'd0, e_run});
        check("tx_valid",   {31'd0, tx_valid},   {31'd0, e_txv});
        check("tx_data",    {24'd0, tx_data},    {24'd0, e_txd});
        if (mem_we) begin
            wlog_addr.push_back(mem_addr); wlog_din.push_back(mem_din); wlog_cyc.push_back(cyc);
        end
        if (tx_valid && tx_ready) begin
            txlog_data.push_back(tx_data); txlog_cyc.push_back(cyc);
        end
        if (cpu_run && !run_prev) run_rise_cyc = cyc;
        run_prev = cpu_run;
    end

    // ---------------- stimulus ----------------
    logic [7:0] sb[0:15];
    int         bcyc[0:15];

    task automatic burst(input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx_valid = 1'b1; rx_data = sb[i]; bcyc[i] = cyc;
            if (gap) begin
                @(negedge clk);
                rx_valid = 1'b0;
            end
        end
        if (!gap) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
    endtask

    task automatic pulse_reload();
        @(negedge clk); reload = 1'b1;
        @(negedge clk); reload = 1'b0;
    endtask

    task automatic clear_logs();
        wlog_addr.delete(); wlog_din.delete(); wlog_cyc.delete();
        txlog_data.delete(); txlog_cyc.delete(); run_rise_cyc = -1;
    endtask

    task automatic wait_run(input int max);
        int i = 0;
        while (cpu_run !== 1'b1 && i < max) begin
            @(negedge clk); i++;
        end
        check("run_timeout", {31'd0, cpu_run}, 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset state
        idle(3);
        check("rst_io_sel", {31'd0, mem_io_sel}, 32'd1);
        check("rst_run",    {31'd0, cpu_run},    32'd0);
        check("rst_we",     {31'd0, mem_we},     32'd0);
        check("rst_addr",   mem_addr,            32'h0);
        check("rst_txv",    {31'd0, tx_valid},   32'd0);
        rst = 1'b0;
        idle(2);

        // Normal load: 2 words
        clear_logs();
        sb[0]=8'h02; sb[1]=8'h00; sb[2]=8'h00; sb[3]=8'h00;
        sb[4]=8'h78; sb[5]=8'h56; sb[6]=8'h34; sb[7]=8'h12;
        sb[8]=8'hEF; sb[9]=8'hBE; sb[10]=8'hAD; sb[11]=8'hDE;
        burst(12, 1'b1);
        wait_run(20);
        idle(2);
        check("norm_nwrites", wlog_addr.size(), 32'd2);
        if (wlog_addr.size() == 2) begin
            check("norm_addr0", wlog_addr[0], 32'h0);
            check("norm_din0",  wlog_din[0],  32'h12345678);
            check("norm_addr1", wlog_addr[1], 32'h4);
            check("norm_din1",  wlog_din[1],  32'hDEADBEEF);
            check("norm_lat0",  wlog_cyc[0],  bcyc[7] + 1);
            check("norm_lat1",  wlog_cyc[1],  bcyc[11] + 1);
        end
        check("norm_ntx", txlog_data.size(), 32'd1);
        if (txlog_data.size() == 1) begin
            check("norm_txd", {24'd0, txlog_data[0]}, 32'hAA);
            check("norm_run_lat", run_rise_cyc, txlog_cyc[0] + 1);
        end
        check("norm_iosel", {31'd0, mem_io_sel}, 32'd0);
        // Bytes in RUN are ignored
        sb[0]=8'h01; sb[1]=8'h02; sb[2]=8'h03; sb[3]=8'h04;
        burst(4, 1'b0);
        idle(3);
        check("run_ignore", wlog_addr.size(), 32'd2);

        // Zero length
        clear_logs();
        pulse_reload();
        check("reload_run", {31'd0, cpu_run}, 32'd0);
        sb[0]=8'h00; sb[1]=8'h00; sb[2]=8'h00; sb[3]=8'h00;
        burst(4, 1'b1);
        wait_run(20);
        idle(2);
        check("zero_nwrites", wlog_addr.size(), 32'd0);
        check("zero_ntx", txlog_data.size(), 32'd1);
        if (txlog_data.size() == 1) check("zero_txd", {24'd0, txlog_data[0]}, 32'hAA);

        // Oversize
        clear_logs();
        pulse_reload();
        sb[0]=8'h01; sb[1]=8'h80; sb[2]=8'h00; sb[3]=8'h00;
        burst(4, 1'b1);
        idle(20);
        sb[0]=8'h11; sb[1]=8'h22; sb[2]=8'h33; sb[3]=8'h44;
        burst(4, 1'b0);
        idle(20);
        check("over_nwrites", wlog_addr.size(), 32'd0);
        check("over_ntx", txlog_data.size(), 32'd1);
        if (txlog_data.size() == 1) check("over_txd", {24'd0, txlog_data[0]}, 32'hEE);
        check("over_run",   {31'd0, cpu_run},    32'd0);
        check("over_iosel", {31'd0, mem_io_sel}, 32'd1);

        // Reload out of ERR, then mid-word abort, then a good 1-word image
        clear_logs();
        pulse_reload();
        sb[0]=8'h01; sb[1]=8'h00; sb[2]=8'h00; sb[3]=8'h00; sb[4]=8'hAB; sb[5]=8'hCD;
        burst(6, 1'b1);
        pulse_reload();
        idle(3);
        check("abort_nwrites", wlog_addr.size(), 32'd0);
        sb[0]=8'h01; sb[1]=8'h00; sb[2]=8'h00; sb[3]=8'h00;
        sb[4]=8'h11; sb[5]=8'h22; sb[6]=8'h33; sb[7]=8'h44;
        burst(8, 1'b1);
        wait_run(20);
        idle(2);
        check("abort_nwrites2", wlog_addr.size(), 32'd1);
        if (wlog_addr.size() == 1) begin
            check("abort_addr", wlog_addr[0], 32'h0);
            check("abort_din",  wlog_din[0],  32'h44332211);
        end

        // Backpressure
        clear_logs();
        pulse_reload();
        tx_ready = 1'b0;
        sb[0]=8'h01; sb[1]=8'h00; sb[2]=8'h00; sb[3]=8'h00;
        sb[4]=8'h55; sb[5]=8'h66; sb[6]=8'h77; sb[7]=8'h88;
        burst(8, 1'b1);
        idle(10);
        check("bp_txv", {31'd0, tx_valid}, 32'd1);
        check("bp_txd", {24'd0, tx_data},  32'hAA);
        check("bp_run_before", {31'd0, cpu_run}, 32'd0);
        tx_ready = 1'b1;
        @(negedge clk);
        check("bp_run_after",   {31'd0, cpu_run},    32'd1);
        check("bp_iosel_after", {31'd0, mem_io_sel}, 32'd0);
        check("bp_txv_after",   {31'd0, tx_valid},   32'd0);

        // Back-to-back bytes, 3 words
        clear_logs();
        pulse_reload();
        sb[0]=8'h03; sb[1]=8'h00; sb[2]=8'h00; sb[3]=8'h00;
        for (int i = 4; i < 16; i++) sb[i] = 8'((i / 4) * 8'h11 + i);
        burst(16, 1'b0);
        wait_run(20);
        idle(2);
        check("b2b_nwrites", wlog_addr.size(), 32'd3);
        if (wlog_addr.size() == 3) begin
            check("b2b_addr0", wlog_addr[0], 32'h0);
            check("b2b_addr1", wlog_addr[1], 32'h4);
            check("b2b_addr2", wlog_addr[2], 32'h8);
            check("b2b_din0",  wlog_din[0],  32'h18171615);
            check("b2b_din1",  wlog_din[1],  32'h2D2C2B2A);
            check("b2b_din2",  wlog_din[2],  32'h4241403F);
            check("b2b_lat",   wlog_cyc[0],  bcyc[7] + 1);
            check("b2b_gap1",  wlog_cyc[1] - wlog_cyc[0], 32'd4);
            check("b2b_gap2",  wlog_cyc[2] - wlog_cyc[1], 32'd4);
        end

        idle(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
